// File: rtl/uart_tx_if.sv
// Byte handshake between a byte source and uart_tx.
// A byte moves on a clock edge where pi_data_flag and tx_ready are both 1.
interface uart_tx_if;
  logic [7:0] pi_data;
  logic       pi_data_flag;
  logic       tx_ready;

  modport master (output pi_data, output pi_data_flag, input tx_ready);
  modport slave  (input pi_data, input pi_data_flag, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART serialiser: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Handshake: a byte is taken on an edge where pi_data_flag=1 and tx_ready=1; while tx_ready=0 the flag is ignored and the source holds.
module uart_tx #(
  parameter logic [12:0] BAUD_CNT_MAX = 13'd5207,
  parameter logic        PARITY_EN    = 1'b0,
  parameter logic        PARITY_ODD   = 1'b0,
  parameter logic [1:0]  STOP_BITS    = 2'd1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Any STOP_BITS value other than 2 gives a single stop bit.
  localparam logic TWO_STOP = (STOP_BITS == 2'd2);

  state_t      state;
  state_t      state_nxt;
  logic [12:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic        stop_cnt;
  logic [7:0]  shift_reg;
  logic        parity_bit;
  logic        tx_bit;
  logic        bit_end;
  logic        last_stop;
  logic        frame_end;
  logic        accept;

  assign bit_end      = (baud_cnt == BAUD_CNT_MAX);
  assign last_stop    = !TWO_STOP || stop_cnt;
  assign frame_end    = (state == STOP) && bit_end && last_stop;
  assign bus.tx_ready = (state == IDLE) || frame_end;
  assign accept       = bus.pi_data_flag && bus.tx_ready;
  assign tx_done      = frame_end;
  assign state_dbg    = state;

  always_comb begin
    state_nxt = state;
    tx_bit    = 1'b1;
    case (state)
      IDLE: begin
        if (accept) state_nxt = START;
      end
      START: begin
        tx_bit = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx_bit = shift_reg[0];
        if (bit_end && (bit_cnt == 3'd7)) state_nxt = PARITY_EN ? PARITY : STOP;
      end
      PARITY: begin
        tx_bit = parity_bit;
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        tx_bit = 1'b1;
        if (frame_end) state_nxt = accept ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx and tx_busy are registered from the current state, so the line
  // trails the FSM by one cycle; tx_done marks the FSM's last stop cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx      <= tx_bit;
      tx_busy <= (state != IDLE);
      if (accept) begin
        shift_reg  <= bus.pi_data;
        parity_bit <= (^bus.pi_data) ^ PARITY_ODD;
        baud_cnt   <= '0;
        bit_cnt    <= '0;
        stop_cnt   <= 1'b0;
      end else if (state != IDLE) begin
        baud_cnt <= bit_end ? 13'd0 : baud_cnt + 13'd1;
        if (bit_end) begin
          if (state == DATA) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 3'd1;
          end
          if (state == STOP) stop_cnt <= ~stop_cnt;
        end
      end
    end
  end

endmodule
